// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared encodings for the multiply/divide unit.
package mul_div_pkg;

    localparam int unsigned OP_W = 2;

    // Operation encoding on the op port
    typedef enum logic [OP_W-1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        WB   = 2'b11
    } state_e;

endpackage

// File: rtl/mul_div_step.sv
// mul_div_step: one combinational iteration of shift-add multiply or restoring divide.
// The divide mode and its i_div select exist only when MUL_DIV_UNIT_DIV_EN is defined.
module mul_div_step #(
    parameter int unsigned m = 32
) (
`ifdef MUL_DIV_UNIT_DIV_EN
    input  logic         i_div,
`endif
    input  logic [m-1:0] i_hi,
    input  logic [m-1:0] i_lo,
    input  logic [m-1:0] i_opnd,
    output logic [m-1:0] o_hi_c,
    output logic [m-1:0] o_lo_c
);

    logic [m:0] w_sum;

    // Multiply: add the multiplicand when the multiplier LSB is set
    always_comb begin
        w_sum = {1'b0, i_hi};
        if (i_lo[0]) begin
            w_sum = w_sum + {1'b0, i_opnd};
        end
    end

`ifdef MUL_DIV_UNIT_DIV_EN
    logic [m:0] w_rem;
    logic [m:0] w_diff;
    logic       w_ge;

    // Divide: shift next dividend bit into the remainder and trial-subtract the divisor
    always_comb begin
        w_rem  = {i_hi, i_lo[m-1]};
        w_diff = w_rem - {1'b0, i_opnd};
        w_ge   = ~w_diff[m];
    end

    // Mode select; a zero divisor never borrows, giving all-ones quotient and remainder = dividend
    always_comb begin
        if (i_div) begin
            o_hi_c = w_ge ? w_diff[m-1:0] : w_rem[m-1:0];
            o_lo_c = {i_lo[m-2:0], w_ge};
        end else begin
            o_hi_c = w_sum[m:1];
            o_lo_c = {w_sum[0], i_lo[m-1:1]};
        end
    end
`else
    // Multiply only: shift the {carry, hi, lo} product right by one
    always_comb begin
        o_hi_c = w_sum[m:1];
        o_lo_c = {w_sum[0], i_lo[m-1:1]};
    end
`endif

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned MUL/MULHU (and DIVU/REMU with MUL_DIV_UNIT_DIV_EN defined),
// one bit per cycle, writing the result back to a register file in a single WB cycle.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int unsigned n = 5,
    parameter int unsigned m = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [m-1:0]    rs_a,
    input  logic [m-1:0]    rs_b,
    input  logic [n-1:0]    dest,
    output logic            busy,
    output logic            wb_we,
    output logic [n-1:0]    wb_addr,
    output logic [m-1:0]    wb_data
);

    localparam int unsigned CNT_W = $clog2(m) + 1;

    state_e             r_state;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [m-1:0]       r_hi;
    logic [m-1:0]       r_lo;
    logic [m-1:0]       r_opnd;
    logic               r_hi_sel;
    logic [n-1:0]       r_dest;
    logic               r_wb_we;
    logic [n-1:0]       r_wb_addr;
    logic [m-1:0]       r_wb_data;

    logic               w_div_op;
    logic               w_accept;
    logic [m-1:0]       w_hi_nxt;
    logic [m-1:0]       w_lo_nxt;

`ifdef MUL_DIV_UNIT_DIV_EN
    logic               w_div_mode;
    assign w_div_mode = (r_state == DIV);
    assign w_div_op   = op[1];
`else
    assign w_div_op   = 1'b0;
`endif

    // Divide requests are dropped entirely when the divider is not built
    assign w_accept = start && (!op[1] || w_div_op);

    mul_div_step #(
        .m      (m)
    ) u_step (
`ifdef MUL_DIV_UNIT_DIV_EN
        .i_div  (w_div_mode),
`endif
        .i_hi   (r_hi),
        .i_lo   (r_lo),
        .i_opnd (r_opnd),
        .o_hi_c (w_hi_nxt),
        .o_lo_c (w_lo_nxt)
    );

    // Sequencer: capture, iterate m steps, then one registered write-back cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opnd    <= '0;
            r_hi_sel  <= 1'b0;
            r_dest    <= '0;
            r_wb_we   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_wb_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        // Iterated operand sits in r_lo; r_opnd is the addend/divisor
                        r_state  <= w_div_op ? DIV : MUL;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_hi     <= '0;
                        r_lo     <= w_div_op ? rs_a : rs_b;
                        r_opnd   <= w_div_op ? rs_b : rs_a;
                        r_hi_sel <= op[0];
                        r_dest   <= dest;
                    end
                end
                MUL, DIV: begin
                    r_hi <= w_hi_nxt;
                    r_lo <= w_lo_nxt;
                    if (r_cnt == CNT_W'(m - 1)) begin
                        r_cnt   <= '0;
                        r_state <= WB;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                WB: begin
                    // High word holds MULHU product / REMU remainder, low word MUL product / DIVU quotient
                    r_wb_we   <= (r_dest != '0);
                    r_wb_addr <= r_dest;
                    r_wb_data <= r_hi_sel ? r_hi : r_lo;
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign wb_we   = r_wb_we;
    assign wb_addr = r_wb_addr;
    assign wb_data = r_wb_data;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter n, default 5, meaning register address width.
REQ-002 The block SHALL have parameter m, default 32, meaning data width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit, operation request.
REQ-006 The block SHALL have port op, input, 2 bits: 00 MUL low word, 01 MULHU high word unsigned, 10 DIVU quotient, 11 REMU remainder.
REQ-007 The block SHALL have ports rs_a and rs_b, inputs, m bits each: operand A (multiplicand/dividend) and operand B (multiplier/divisor).
REQ-008 The block SHALL have port dest, input, n bits, destination register address.
REQ-009 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not IDLE.
REQ-010 The block SHALL have ports wb_we (1 bit), wb_addr (n bits) and wb_data (m bits), outputs, driving the register-file write enable, write address and write data.

Function
REQ-011 The FSM SHALL have states IDLE, MUL, DIV and WB.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL capture op, rs_a, rs_b and dest, then enter MUL (op 0x) or DIV (op 1x).
REQ-013 start SHALL be ignored in every state other than IDLE; captured operands SHALL NOT change.
REQ-014 MUL SHALL be unsigned shift-add, one bit per cycle, exactly m cycles, into a 2m-bit product.
REQ-015 DIV SHALL be unsigned restoring division, one bit per cycle, exactly m cycles.
REQ-016 An iteration counter SHALL be ceil(log2(m))+1 bits wide and SHALL leave MUL/DIV for WB when the count reaches m-1.
REQ-017 WB SHALL last one cycle, then return to IDLE.
REQ-018 wb_we SHALL be high only in WB and only if the captured dest != 0; writes to register 0 are suppressed.
REQ-019 wb_we SHALL rise at the clock edge m+1 edges after the edge that sampled start (33 for m=32); the next start SHALL be accepted on the edge after WB.
REQ-020 wb_data SHALL be: MUL product[m-1:0]; MULHU product[2m-1:m]; DIVU quotient; REMU remainder.
REQ-021 When the divisor is 0, DIVU SHALL return all ones and REMU SHALL return the dividend; the cycle count SHALL be unchanged.
REQ-022 wb_addr and wb_data SHALL be registered and held stable from WB until the next accepted start; wb_we SHALL be registered.

Reset
REQ-023 While rst_n=0, the block SHALL force the state to IDLE and busy=0, wb_we=0, wb_addr=0, wb_data=0, counter=0 and all operand/accumulator registers to 0.
REQ-024 A reset asserted mid-operation SHALL abort the operation, and no wb_we pulse SHALL follow.

Configuration
REQ-025 With macro MUL_DIV_UNIT_DIV_EN defined, the block SHALL implement the DIV state and ops 10/11.
REQ-026 Without MUL_DIV_UNIT_DIV_EN, the DIV datapath SHALL be absent; start with op 1x SHALL be ignored (busy stays 0, no wb_we); MUL ops SHALL be unchanged.

Structure
REQ-027 Package mul_div_pkg SHALL hold the op encoding enum, the FSM state enum and localparam OP_W=2.
REQ-028 Per-cycle add/subtract-and-shift SHALL reside in one sub-module, mul_div_step, a combinational step selected by mode; the FSM, counter and registers SHALL stay in mul_div_unit.

Verification
REQ-029 Scenario: MUL rs_a=7, rs_b=6, dest=3 -> wb_we pulses 1 cycle at edge 33, wb_addr=3, wb_data=42.
REQ-030 Scenario: MULHU 0xFFFFFFFF x 0xFFFFFFFF, dest=5 -> wb_data=0xFFFFFFFE; MUL with the same operands -> 0x00000001.
REQ-031 Scenario: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x12345678/0 -> 0xFFFFFFFF; REMU 0x12345678/0 -> 0x12345678.
REQ-032 Scenario: start pulsed again with different operands at edge 10 of a MUL -> ignored, result still that of the first operation; back-to-back start on the edge after WB -> accepted.
REQ-033 Scenario: rst_n low at iteration 10 of DIVU -> busy=0, wb_we=0 immediately, no later write; dest=0 MUL -> busy completes, wb_we never asserted.
REQ-034 Scenario: build without MUL_DIV_UNIT_DIV_EN, start with op=10 -> busy stays 0 and wb_we stays 0 for 40 cycles.
